seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for the ATM's common 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl: multiplexed 7-segment scan with guard blanking, tear-free   |
// | frame-synchronous display register and optional leading-zero blanking.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    lz_blank,
  input  logic [6:0]              seg_in,
  output logic [3:0]              bcd_out,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    updated
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [0:0]    ST_GUARD   = 1'b0;
  localparam logic [0:0]    ST_SHOW    = 1'b1;

  logic [CW-1:0]           cnt, cnt_next;
  logic [DW-1:0]           digit, digit_next;
  logic [0:0]              state, state_next;
  logic                    wrap, boundary;
  logic [4*NUM_DIGITS-1:0] disp_reg, disp_next, pend_reg;
  logic                    pend_valid;
  logic [NUM_DIGITS-1:0]   blank, an_next;
  logic                    zeros_above;
  logic [3:0]              nib_next;

  assign wrap       = (cnt == CNT_LAST);
  assign boundary   = wrap && (digit == DIGIT_LAST);
  assign cnt_next   = wrap ? '0 : cnt + 1'b1;
  assign digit_next = !wrap ? digit : ((digit == DIGIT_LAST) ? '0 : digit + 1'b1);

  // State register (with the slot counters it is sequenced by)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_GUARD;
      cnt   <= '0;
      digit <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      digit <= digit_next;
    end
  end

  // Next state follows the counter value the next cycle will hold
  always_comb begin
    state_next = ST_GUARD;
    if (cnt_next >= GUARD_END) state_next = ST_SHOW;
  end

  // Outputs: anode pattern prepared one cycle ahead, seg gated by current state
  always_comb begin
    an_next = '1;
    if (state_next == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_next == DW'(i)) an_next[i] = 1'b0;
      end
    end
    seg = (state == ST_SHOW) ? seg_in : 7'b1111111;
  end

  // Value the display register holds after this edge
  always_comb begin
    disp_next = disp_reg;
    if (boundary) begin
      if (load)            disp_next = value_bcd;
      else if (pend_valid) disp_next = pend_reg;
    end
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 never
  always_comb begin
    zeros_above = 1'b1;
    blank       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (disp_next[4*i +: 4] == 4'h0);
      blank[i]    = lz_blank && zeros_above;
    end
  end

  always_comb begin
    nib_next = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_next == DW'(i)) nib_next = blank[i] ? 4'hF : disp_next[4*i +: 4];
    end
  end

  // bcd_out is only reloaded at slot start so blanking changes never tear a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an      <= '1;
      bcd_out <= 4'hF;
    end else begin
      an <= an_next;
      if (wrap) bcd_out <= nib_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg   <= {NUM_DIGITS{4'hF}};
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      updated    <= 1'b0;
    end else begin
      disp_reg <= disp_next;
      updated  <= boundary && (load || pend_valid);
      if (boundary) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_reg   <= value_bcd;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_seg_scan_ctrl: directed vector bench for seg_scan_ctrl (4 digits,       |
// | 8-cycle slots, 2-cycle guard). Revision: 1.0                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_bcd = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg_in;
  logic [3:0]  bcd_out;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        updated;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction

  assign seg_in = dec(bcd_out);

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value_bcd(value_bcd),
    .lz_blank(lz_blank), .seg_in(seg_in), .bcd_out(bcd_out), .seg(seg),
    .an(an), .updated(updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // Anodes one-hot-low at most, and segments dark whenever no anode is on
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ($countones(~an) > 1 || (an == 4'b1111 && seg != 7'b1111111)) begin
        errors++;
        $display("FAIL scan_invariant @cycle %0d: an=%b seg=%b", cyc, an, seg);
      end
    end
  end

  typedef struct {
    int          c;
    logic        ld;
    logic [15:0] val;
    logic        lz;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        upd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int c, input logic ld, input logic [15:0] val, input logic lz,
                     input logic [3:0] a, input logic [3:0] b, input logic u);
    vec_t v;
    v.c = c; v.ld = ld; v.val = val; v.lz = lz; v.an = a; v.bcd = b; v.upd = u;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input logic [3:0] a, input logic [3:0] b, input logic u);
    chk("an", {12'h0, an}, {12'h0, a});
    chk("bcd_out", {12'h0, bcd_out}, {12'h0, b});
    chk("updated", {15'h0, updated}, {15'h0, u});
    chk("seg", {9'h0, seg}, {9'h0, (a == 4'b1111) ? 7'b1111111 : dec(b)});
  endtask

  initial begin
    // Frame 0: blank display; load 1234 at cycle 3
    add(0,   0, 16'h0000, 0, 4'b1111, 4'hF, 0);
    add(1,   0, 16'h0000, 0, 4'b1111, 4'hF, 0);
    add(2,   0, 16'h0000, 0, 4'b1110, 4'hF, 0);
    add(3,   1, 16'h1234, 0, 4'b1110, 4'hF, 0);
    add(7,   0, 16'h0000, 0, 4'b1110, 4'hF, 0);
    add(8,   0, 16'h0000, 0, 4'b1111, 4'hF, 0);
    add(10,  0, 16'h0000, 0, 4'b1101, 4'hF, 0);
    add(31,  0, 16'h0000, 0, 4'b0111, 4'hF, 0);
    // Frame 1: 1234 shown; lz_blank raised mid-slot with a load of 0070
    add(32,  0, 16'h0000, 0, 4'b1111, 4'h4, 1);
    add(33,  0, 16'h0000, 0, 4'b1111, 4'h4, 0);
    add(34,  0, 16'h0000, 0, 4'b1110, 4'h4, 0);
    add(42,  0, 16'h0000, 0, 4'b1101, 4'h3, 0);
    add(50,  0, 16'h0000, 0, 4'b1011, 4'h2, 0);
    add(58,  0, 16'h0000, 0, 4'b0111, 4'h1, 0);
    add(60,  1, 16'h0070, 1, 4'b0111, 4'h1, 0);
    add(62,  0, 16'h0000, 1, 4'b0111, 4'h1, 0);
    // Frame 2: 0070 with leading-zero blanking; then load 0000
    add(64,  0, 16'h0000, 1, 4'b1111, 4'h0, 1);
    add(66,  0, 16'h0000, 1, 4'b1110, 4'h0, 0);
    add(74,  0, 16'h0000, 1, 4'b1101, 4'h7, 0);
    add(82,  0, 16'h0000, 1, 4'b1011, 4'hF, 0);
    add(90,  1, 16'h0000, 1, 4'b0111, 4'hF, 0);
    // Frame 3: 0000 blanked except digit 0; lz_blank dropped at the end
    add(96,  0, 16'h0000, 1, 4'b1111, 4'h0, 1);
    add(98,  0, 16'h0000, 1, 4'b1110, 4'h0, 0);
    add(106, 0, 16'h0000, 1, 4'b1101, 4'hF, 0);
    add(114, 0, 16'h0000, 1, 4'b1011, 4'hF, 0);
    add(122, 0, 16'h0000, 0, 4'b0111, 4'hF, 0);
    // Frame 4: zeros shown unblanked; two loads, last one wins
    add(128, 0, 16'h0000, 0, 4'b1111, 4'h0, 0);
    add(138, 1, 16'h1111, 0, 4'b1101, 4'h0, 0);
    add(148, 1, 16'h2222, 0, 4'b1011, 4'h0, 0);
    add(159, 0, 16'h0000, 0, 4'b0111, 4'h0, 0);
    // Frame 5: 2222; load on the boundary cycle itself
    add(160, 0, 16'h0000, 0, 4'b1111, 4'h2, 1);
    add(161, 0, 16'h0000, 0, 4'b1111, 4'h2, 0);
    add(170, 0, 16'h0000, 0, 4'b1101, 4'h2, 0);
    add(191, 1, 16'h5678, 0, 4'b0111, 4'h2, 0);
    add(192, 0, 16'h0000, 0, 4'b1111, 4'h8, 1);
    add(193, 0, 16'h0000, 0, 4'b1111, 4'h8, 0);
    // Frame 7: nothing was left pending
    add(224, 0, 16'h0000, 0, 4'b1111, 4'h8, 0);
    add(226, 0, 16'h0000, 0, 4'b1110, 4'h8, 0);
    add(250, 0, 16'h0000, 0, 4'b0111, 4'h5, 0);

    #12;
    chk_outs(4'b1111, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;

    foreach (vecs[k]) begin
      tick_to(vecs[k].c);
      chk_outs(vecs[k].an, vecs[k].bcd, vecs[k].upd);
      load      = vecs[k].ld;
      value_bcd = vecs[k].val;
      lz_blank  = vecs[k].lz;
    end

    // Mid-operation reset with a pending value
    lz_blank = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_outs(4'b1111, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    chk_outs(4'b1111, 4'hF, 1'b0);
    tick_to(10);
    load = 1'b1; value_bcd = 16'h9999;
    tick_to(13);
    #2;
    reset = 1'b1;
    #1;
    chk_outs(4'b1111, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    chk_outs(4'b1111, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    chk_outs(4'b1111, 4'hF, 1'b0);
    tick_to(2);
    chk_outs(4'b1110, 4'hF, 1'b0);
    tick_to(8);
    chk_outs(4'b1111, 4'hF, 1'b0);
    tick_to(32);
    chk_outs(4'b1111, 4'hF, 1'b0);
    tick_to(34);
    chk_outs(4'b1110, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
